// File: rtl/pat_chain_seq.sv
// rtl/pat_chain_seq.sv - test sequencer driving a pattern generator chain and checking its output against a golden count
module pat_chain_seq #(
    parameter int N        = 4,
    parameter int LIM      = 14,
    parameter int CW       = 16,
    parameter int PIPE_LAT = 2,
    parameter int INJ_LEN  = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [CW-1:0] run_len_i,
    input  logic          inj_en_i,
    input  logic [CW-1:0] inj_at_i,
    input  logic [N-1:0]  gen_data_i,
    input  logic [N-1:0]  chain_data_i,
    output logic          pat_inc_o,
    output logic          inj_err_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          pass_o,
    output logic [CW-1:0] err_cnt_o,
    output logic [CW-1:0] first_err_o,
    output logic          gen_err_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam int DW = $clog2(PIPE_LAT + 1) + 1;
    localparam logic [CW-1:0] ONE_CW    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] SAT_CW    = {CW{1'b1}};
    localparam logic [CW-1:0] INJ_LEN_W = CW'(INJ_LEN);
    localparam logic [N-1:0]  LIM_W     = N'(LIM);
    localparam logic [DW-1:0] DRAIN_END = DW'(PIPE_LAT);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_tc;
    logic [DW-1:0] r_dcnt;
    logic [CW-1:0] r_run_len;
    logic          r_inj_en;
    logic [CW-1:0] r_inj_at;
    logic [N-1:0]  r_mdl;
    logic [N-1:0]  r_dly [PIPE_LAT];
    logic          r_vld [PIPE_LAT];

    logic          r_pat_inc;
    logic          r_inj_err;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;
    logic [CW-1:0] r_err_cnt;
    logic [CW-1:0] r_first_err;
    logic          r_gen_err;

    logic          w_start;
    logic          w_active;
    logic          w_inj_en;
    logic [CW-1:0] w_inj_at;
    logic [CW-1:0] w_tc_nxt;
    logic          w_inj_nxt;
    logic          w_mis;
    logic [CW-1:0] w_err_nxt;
    logic [CW-1:0] w_first_nxt;
    logic          w_gen_err_nxt;
    logic          w_pass_nxt;

    assign pat_inc_o   = r_pat_inc;
    assign inj_err_o   = r_inj_err;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign pass_o      = r_pass;
    assign err_cnt_o   = r_err_cnt;
    assign first_err_o = r_first_err;
    assign gen_err_o   = r_gen_err;

    // Next state: abort beats the normal RUN/DRAIN exits, start is only seen in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = (run_len_i == '0) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    w_state_nxt = S_IDLE;
                end else if (r_tc == r_run_len - ONE_CW) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort_i) begin
                    w_state_nxt = S_IDLE;
                end else if (r_dcnt == DRAIN_END) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, computed from the upcoming state and cycle index
    always_comb begin
        w_start  = (r_state == S_IDLE) && start_i;
        w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
        w_inj_en = w_start ? inj_en_i : r_inj_en;
        w_inj_at = w_start ? inj_at_i : r_inj_at;
        w_tc_nxt = r_tc;
        if (w_start) begin
            w_tc_nxt = '0;
        end else if (w_active) begin
            w_tc_nxt = r_tc + ONE_CW;
        end
        // The window closes naturally when the state leaves RUN, which truncates late injections
        w_inj_nxt = (w_state_nxt == S_RUN) && w_inj_en && (w_tc_nxt >= w_inj_at) &&
                    ((w_tc_nxt - w_inj_at) < INJ_LEN_W);
        w_mis = w_active && r_vld[PIPE_LAT-1] && (chain_data_i != r_dly[PIPE_LAT-1]);

        w_err_nxt     = r_err_cnt;
        w_first_nxt   = r_first_err;
        w_gen_err_nxt = r_gen_err;
        w_pass_nxt    = r_pass;
        if (w_start) begin
            w_err_nxt     = '0;
            w_first_nxt   = '0;
            w_gen_err_nxt = 1'b0;
            w_pass_nxt    = 1'b0;
        end else begin
            if (w_mis && (r_err_cnt != SAT_CW)) begin
                w_err_nxt = r_err_cnt + ONE_CW;
            end
            if (w_mis && (r_err_cnt == '0)) begin
                w_first_nxt = r_tc;
            end
            if ((r_state == S_RUN) && (gen_data_i != r_mdl)) begin
                w_gen_err_nxt = 1'b1;
            end
            if (w_state_nxt == S_DONE) begin
                w_pass_nxt = (w_err_nxt == '0) && !w_gen_err_nxt;
            end
        end
    end

    // State, run parameters, counters and registered outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= S_IDLE;
            r_tc        <= '0;
            r_dcnt      <= '0;
            r_run_len   <= '0;
            r_inj_en    <= 1'b0;
            r_inj_at    <= '0;
            r_pat_inc   <= 1'b0;
            r_inj_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_gen_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tc    <= w_tc_nxt;
            r_dcnt  <= (r_state == S_DRAIN) ? r_dcnt + 1'b1 : '0;
            if (w_start) begin
                r_run_len <= run_len_i;
                r_inj_en  <= inj_en_i;
                r_inj_at  <= inj_at_i;
            end
            r_pat_inc   <= (w_state_nxt == S_RUN);
            r_inj_err   <= w_inj_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);
            r_pass      <= w_pass_nxt;
            r_err_cnt   <= w_err_nxt;
            r_first_err <= w_first_nxt;
            r_gen_err   <= w_gen_err_nxt;
        end
    end

    // Golden generator count; only a hard reset realigns it, so it follows the generator across runs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mdl <= '0;
        end else if (r_pat_inc) begin
            r_mdl <= (r_mdl == LIM_W) ? '0 : r_mdl + 1'b1;
        end
    end

    // Delay the model and its RUN-valid flag to line up with the end of the chain
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_dly[i] <= '0;
                r_vld[i] <= 1'b0;
            end
        end else begin
            r_dly[0] <= r_mdl;
            r_vld[0] <= (r_state == S_RUN);
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_dly[i] <= r_dly[i-1];
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

endmodule

// File: tb/tb_pat_chain_seq.sv
// tb/tb_pat_chain_seq.sv - directed table-driven bench for pat_chain_seq
module tb_pat_chain_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i, abort_i, inj_en_i;
    logic [15:0] run_len_i, inj_at_i;
    logic [3:0]  gen_data_i, chain_data_i;
    logic        pat_inc_o, inj_err_o, busy_o, done_o, pass_o, gen_err_o;
    logic [15:0] err_cnt_o, first_err_o;
    logic        b_pat_inc, b_inj_err, b_busy, b_done, b_pass, b_gen_err;
    logic [15:0] b_err_cnt, b_first_err;

    always #5 clk = ~clk;

    pat_chain_seq dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start_i), .abort_i(abort_i),
        .run_len_i(run_len_i), .inj_en_i(inj_en_i), .inj_at_i(inj_at_i),
        .gen_data_i(gen_data_i), .chain_data_i(chain_data_i),
        .pat_inc_o(pat_inc_o), .inj_err_o(inj_err_o), .busy_o(busy_o), .done_o(done_o),
        .pass_o(pass_o), .err_cnt_o(err_cnt_o), .first_err_o(first_err_o), .gen_err_o(gen_err_o)
    );

    pat_chain_seq #(.INJ_LEN(2)) dut2 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start_i), .abort_i(abort_i),
        .run_len_i(run_len_i), .inj_en_i(inj_en_i), .inj_at_i(inj_at_i),
        .gen_data_i(gen_data_i), .chain_data_i(chain_data_i),
        .pat_inc_o(b_pat_inc), .inj_err_o(b_inj_err), .busy_o(b_busy), .done_o(b_done),
        .pass_o(b_pass), .err_cnt_o(b_err_cnt), .first_err_o(b_first_err), .gen_err_o(b_gen_err)
    );

    // Ideal generator (0..14 wrap) followed by two single-cycle stages; corrupt flips the chain output
    logic [3:0] g_cnt, c1, c2;
    logic       corrupt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_cnt <= '0;
            c1    <= '0;
            c2    <= '0;
        end else begin
            if (pat_inc_o) g_cnt <= (g_cnt == 4'd14) ? 4'd0 : g_cnt + 4'd1;
            c1 <= g_cnt;
            c2 <= c1;
        end
    end
    assign gen_data_i   = g_cnt;
    assign chain_data_i = c2 ^ (corrupt ? 4'hF : 4'h0);

    typedef struct {
        int len; bit en; int at; int cs; int cl;
        int e_inc; int e_done; int e_err; int e_first; bit e_pass;
        int e_inj; int e_inj_tc; int e_inj2;
    } vec_t;
    vec_t vecs[5];

    int errors = 0;
    int checks = 0;
    int cyc_since, cnt_inc, cnt_inj, cnt_inj2, cnt_done, done_at, inj_tc;
    int cor_s, cor_l;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc_since++;
        corrupt = (cor_l > 0) && (cyc_since - 1 >= cor_s) && (cyc_since - 1 < cor_s + cor_l);
        if (pat_inc_o) cnt_inc++;
        if (inj_err_o) begin
            if (cnt_inj == 0) inj_tc = cyc_since - 1;
            cnt_inj++;
        end
        if (b_inj_err) cnt_inj2++;
        if (done_o) begin
            cnt_done++;
            done_at = cyc_since;
        end
    endtask

    task automatic start_run(input int len, input bit en, input int at);
        @(negedge clk);
        start_i   = 1'b1;
        run_len_i = 16'(len);
        inj_en_i  = en;
        inj_at_i  = 16'(at);
        @(posedge clk);
        #1;
        start_i   = 1'b0;
        cyc_since = 0; cnt_inc = 0; cnt_inj = 0; cnt_inj2 = 0;
        cnt_done  = 0; done_at = -1; inj_tc = -1;
    endtask

    task automatic run_to_done(input string nm, input int budget);
        int b;
        b = 0;
        while (cnt_done == 0 && b < budget) begin
            step();
            b++;
        end
        if (cnt_done == 0) chk({nm, "_timeout"}, 0, 1);
        step();
        step();
    endtask

    task automatic run_vec(input int i);
        string nm;
        nm = $sformatf("vec%0d", i);
        cor_s = vecs[i].cs;
        cor_l = vecs[i].cl;
        start_run(vecs[i].len, vecs[i].en, vecs[i].at);
        run_to_done(nm, vecs[i].len + 40);
        chk({nm, "_inc"},     cnt_inc, vecs[i].e_inc);
        chk({nm, "_done_at"}, done_at, vecs[i].e_done);
        chk({nm, "_done_n"},  cnt_done, 1);
        chk({nm, "_err"},     int'(err_cnt_o), vecs[i].e_err);
        chk({nm, "_first"},   int'(first_err_o), vecs[i].e_first);
        chk({nm, "_pass"},    int'(pass_o), int'(vecs[i].e_pass));
        chk({nm, "_generr"},  int'(gen_err_o), 0);
        chk({nm, "_inj"},     cnt_inj, vecs[i].e_inj);
        chk({nm, "_inj_tc"},  inj_tc, vecs[i].e_inj_tc);
        chk({nm, "_inj2"},    cnt_inj2, vecs[i].e_inj2);
        chk({nm, "_busy"},    int'(busy_o), 0);
    endtask

    function automatic int all_out();
        return int'(pat_inc_o) + int'(inj_err_o) + int'(busy_o) + int'(done_o) + int'(pass_o) +
               int'(gen_err_o) + int'(err_cnt_o) + int'(first_err_o);
    endfunction

    initial begin
        rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; inj_en_i = 1'b0;
        run_len_i = '0; inj_at_i = '0; corrupt = 1'b0; cor_s = 0; cor_l = 0;
        cyc_since = 0; cnt_inc = 0; cnt_inj = 0; cnt_inj2 = 0; cnt_done = 0; done_at = -1; inj_tc = -1;

        //           len en at cs cl  inc done err first pass inj inj_tc inj2
        vecs[0] = '{20, 0, 0, 0, 0,  20, 24,  0, 0,    1,   0,  -1,    0};
        vecs[1] = '{40, 0, 0, 0, 0,  40, 44,  0, 0,    1,   0,  -1,    0};
        vecs[2] = '{20, 1, 5, 8, 3,  20, 24,  3, 8,    0,   1,   5,    2};
        vecs[3] = '{0,  0, 0, 0, 0,   0,  4,  0, 0,    1,   0,  -1,    0};
        vecs[4] = '{10, 1, 9, 0, 0,  10, 14,  0, 0,    1,   1,   9,    1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_out(), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(i);

        // start while busy must not restart or change the run length
        cor_l = 0;
        start_run(10, 0, 0);
        while (cyc_since < 3) step();
        start_i = 1'b1;
        run_len_i = 16'd50;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        run_to_done("busy_start", 60);
        chk("busy_start_inc", cnt_inc, 10);
        chk("busy_start_done_at", done_at, 14);
        chk("busy_start_pass", int'(pass_o), 1);

        // abort during cycle 10 of a 50-cycle run
        start_run(50, 0, 0);
        while (cyc_since < 11) step();
        abort_i = 1'b1;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        chk("abort_inc_drop", int'(pat_inc_o), 0);
        chk("abort_busy_drop", int'(busy_o), 0);
        repeat (10) step();
        chk("abort_no_done", cnt_done, 0);
        chk("abort_pass", int'(pass_o), 0);
        chk("abort_inc_cnt", cnt_inc, 11);
        start_run(12, 0, 0);
        run_to_done("after_abort", 60);
        chk("after_abort_pass", int'(pass_o), 1);
        chk("after_abort_inc", cnt_inc, 12);

        // asynchronous reset in the middle of RUN
        start_run(30, 0, 0);
        while (cyc_since < 8) step();
        chk("pre_reset_busy", int'(busy_o), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", all_out(), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        start_run(15, 0, 0);
        run_to_done("after_reset", 60);
        chk("after_reset_pass", int'(pass_o), 1);
        chk("after_reset_done_at", done_at, 19);
        chk("after_reset_err", int'(err_cnt_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
